// File: rtl/time_pkg.sv
// Shared constants, the hh:mm:pm record and the 12-hour increment rule
// used by both the time-of-day and the alarm registers.
package time_pkg;

    localparam logic [6:0] MIN_MAX = 7'd59;
    localparam logic [6:0] SEC_MAX = 7'd59;
    localparam logic [6:0] HRS_MAX = 7'd12;
    localparam logic [6:0] HRS_MIN = 7'd1;

    typedef struct packed {
        logic [6:0] hrs;
        logic [6:0] min;
        logic       pm;
    } hm_t;

    localparam hm_t TIME_RST  = '{hrs: 7'd12, min: 7'd0, pm: 1'b0};
    localparam hm_t ALARM_RST = '{hrs: 7'd6,  min: 7'd0, pm: 1'b0};

    // 11->12 flips AM/PM, 12->1 keeps it; minutes are passed through.
    function automatic hm_t hrs_step(hm_t v);
        hm_t r;
        r = v;
        if (v.hrs == HRS_MAX) begin
            r.hrs = HRS_MIN;
        end else begin
            r.hrs = v.hrs + 7'd1;
            if (v.hrs == HRS_MAX - 7'd1) r.pm = ~v.pm;
        end
        return r;
    endfunction

endpackage

// File: rtl/hm_reg.sv
// One hh:mm:pm register. Minutes may optionally carry into hours; a separate
// hour strobe applies the 12-hour rule directly.
module hm_reg import time_pkg::*; #(
    parameter hm_t RST_VAL = TIME_RST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic min_inc,
    input  logic min_carry_en,
    input  logic hrs_inc,
    output hm_t  val
);

    hm_t nxt;

    always_comb begin
        nxt = val;
        if (min_inc) begin
            if (val.min == MIN_MAX) begin
                nxt.min = 7'd0;
                if (min_carry_en) nxt = hrs_step(nxt);
            end else begin
                nxt.min = val.min + 7'd1;
            end
        end
        if (hrs_inc) nxt = hrs_step(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val <= RST_VAL;
        else        val <= nxt;
    end

endmodule

// File: rtl/time_alarm_driver.sv
// Time-of-day / alarm-set engine with a timed, latched ring output.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module time_alarm_driver import time_pkg::*; #(
    parameter int TICKS_PER_SEC = 1,
    parameter int RING_SEC      = 30,
    parameter int SNOOZE_SEC    = 300
) (
    input  logic       Pulse,
    input  logic       Reset_n,
    input  logic       Timeset,
    input  logic       Alarmset,
    input  logic       Minadv,
    input  logic       Hrsadv,
    input  logic       Alarmon,
    input  logic       buzz,
    output logic [6:0] tsec,
    output logic [6:0] tmin,
    output logic [6:0] thrs,
    output logic       tpm,
    output logic [6:0] amin,
    output logic [6:0] ahrs,
    output logic       apm,
    output logic       alarm_out
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RW = $clog2(RING_SEC + 1);
    localparam logic [PW-1:0] PRE_TOP  = PW'(TICKS_PER_SEC - 1);
    localparam logic [RW-1:0] RING_LD  = RW'(RING_SEC);

    logic [PW-1:0] presc;
    logic          sec_tick;
    logic          alarm_edit;
    logic [RW-1:0] ring_cnt;
    logic          buzz_d;
    logic          trigger;
    logic          snooze_req;
    logic          retrig;
    hm_t           t_hm;
    hm_t           a_hm;

    assign sec_tick   = !Timeset && (presc == PRE_TOP);
    assign alarm_edit = Alarmset && !Timeset;
    assign trigger    = buzz && !buzz_d;

    always_ff @(posedge Pulse or negedge Reset_n) begin
        if (!Reset_n)                presc <= '0;
        else if (Timeset || sec_tick) presc <= '0;
        else                         presc <= presc + PW'(1);
    end

    always_ff @(posedge Pulse or negedge Reset_n) begin
        if (!Reset_n)      tsec <= 7'd0;
        else if (Timeset)  tsec <= 7'd0;
        else if (sec_tick) tsec <= (tsec == SEC_MAX) ? 7'd0 : tsec + 7'd1;
    end

    // In set mode minutes wrap on their own; in run mode they carry into hours.
    hm_reg #(.RST_VAL(TIME_RST)) u_time (
        .clk          (Pulse),
        .rst_n        (Reset_n),
        .min_inc      (Timeset ? Minadv : (sec_tick && tsec == SEC_MAX)),
        .min_carry_en (!Timeset),
        .hrs_inc      (Timeset && Hrsadv),
        .val          (t_hm)
    );

    hm_reg #(.RST_VAL(ALARM_RST)) u_alarm (
        .clk          (Pulse),
        .rst_n        (Reset_n),
        .min_inc      (alarm_edit && Minadv),
        .min_carry_en (1'b0),
        .hrs_inc      (alarm_edit && Hrsadv),
        .val          (a_hm)
    );

    assign thrs = t_hm.hrs;
    assign tmin = t_hm.min;
    assign tpm  = t_hm.pm;
    assign ahrs = a_hm.hrs;
    assign amin = a_hm.min;
    assign apm  = a_hm.pm;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    logic [SW-1:0] snooze_cnt;

    assign snooze_req = Minadv && alarm_out && !Timeset && !Alarmset;
    assign retrig     = sec_tick && (snooze_cnt == SW'(1));

    always_ff @(posedge Pulse or negedge Reset_n) begin
        if (!Reset_n)                         snooze_cnt <= '0;
        else if (!Alarmon)                    snooze_cnt <= '0;
        else if (snooze_req)                  snooze_cnt <= SW'(SNOOZE_SEC);
        else if (sec_tick && snooze_cnt != '0) snooze_cnt <= snooze_cnt - SW'(1);
    end
`else
    assign snooze_req = 1'b0;
    assign retrig     = 1'b0;
`endif

    // Alarmon has top priority; a fresh buzz edge or snooze expiry reloads the ring.
    always_ff @(posedge Pulse or negedge Reset_n) begin
        if (!Reset_n) begin
            buzz_d    <= 1'b0;
            alarm_out <= 1'b0;
            ring_cnt  <= '0;
        end else begin
            buzz_d <= buzz;
            if (!Alarmon || snooze_req) begin
                alarm_out <= 1'b0;
                ring_cnt  <= '0;
            end else if (trigger || retrig) begin
                alarm_out <= 1'b1;
                ring_cnt  <= RING_LD;
            end else if (sec_tick && alarm_out) begin
                ring_cnt <= ring_cnt - RW'(1);
                if (ring_cnt == RW'(1)) alarm_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_time_alarm_driver.sv
// Directed bench for time_alarm_driver; the reference keeps time as seconds
// of the day and the alarm as minutes of the day.
module tb_time_alarm_driver;

    localparam int RING = 30;
    localparam int SNZ  = 300;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       Pulse, Reset_n, Timeset, Alarmset, Minadv, Hrsadv, Alarmon, buzz;
    logic [6:0] tsec, tmin, thrs, amin, ahrs;
    logic       tpm, apm, alarm_out;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state
    int m_sod, m_amod, m_ring, m_snz;
    bit m_out, m_buzz_d;

    time_alarm_driver #(.TICKS_PER_SEC(1), .RING_SEC(RING), .SNOOZE_SEC(SNZ)) dut (
        .Pulse(Pulse), .Reset_n(Reset_n), .Timeset(Timeset), .Alarmset(Alarmset),
        .Minadv(Minadv), .Hrsadv(Hrsadv), .Alarmon(Alarmon), .buzz(buzz),
        .tsec(tsec), .tmin(tmin), .thrs(thrs), .tpm(tpm),
        .amin(amin), .ahrs(ahrs), .apm(apm), .alarm_out(alarm_out)
    );

    // external comparator: hh:mm:pm match
    assign buzz = (thrs == ahrs) && (tmin == amin) && (tpm == apm);

    initial begin
        Pulse = 1'b0;
        forever #5 Pulse = ~Pulse;
    end

    function automatic int h12(int h24);
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sod = 0; m_amod = 6 * 60; m_ring = 0; m_snz = 0; m_out = 0; m_buzz_d = 0;
    endtask

    always @(negedge Pulse) begin
        check("tsec", tsec, m_sod % 60);
        check("tmin", tmin, (m_sod / 60) % 60);
        check("thrs", thrs, h12(m_sod / 3600));
        check("tpm",  tpm,  int'(m_sod >= 12 * 3600));
        check("amin", amin, m_amod % 60);
        check("ahrs", ahrs, h12(m_amod / 60));
        check("apm",  apm,  int'(m_amod >= 12 * 60));
        check("alarm_out", alarm_out, int'(m_out));
    end

    // Advance one edge: derive next reference state from the current inputs.
    task automatic step(int n = 1);
        for (int k = 0; k < n; k++) begin
            int h, mi, n_sod, n_amod, n_ring, n_snz;
            bit tk, mb, n_out, req, retr;
            tk = !Timeset;
            mb = (m_sod / 60) == m_amod;
            h  = m_sod / 3600;
            mi = (m_sod / 60) % 60;
            n_sod = m_sod; n_amod = m_amod; n_ring = m_ring; n_snz = m_snz; n_out = m_out;
            if (Timeset) begin
                n_sod = (Hrsadv ? (h + 1) % 24 : h) * 3600 + (Minadv ? (mi + 1) % 60 : mi) * 60;
            end else begin
                n_sod = (m_sod + 1) % 86400;
                if (Alarmset)
                    n_amod = (Hrsadv ? (m_amod / 60 + 1) % 24 : m_amod / 60) * 60
                           + (Minadv ? (m_amod % 60 + 1) % 60 : m_amod % 60);
            end
            req = SNZ_EN && Minadv && m_out && !Timeset && !Alarmset;
            if (!Alarmon) begin
                n_out = 0; n_ring = 0; n_snz = 0;
            end else if (req) begin
                n_out = 0; n_ring = 0; n_snz = SNZ;
            end else begin
                retr = SNZ_EN && tk && m_snz == 1;
                if (tk && m_snz > 0) n_snz = m_snz - 1;
                if ((mb && !m_buzz_d) || retr) begin
                    n_out = 1; n_ring = RING;
                end else if (tk && m_out) begin
                    n_ring = m_ring - 1;
                    if (n_ring == 0) n_out = 0;
                end
            end
            @(posedge Pulse);
            m_sod = n_sod; m_amod = n_amod; m_ring = n_ring; m_snz = n_snz;
            m_out = n_out; m_buzz_d = mb;
            #1;
        end
    endtask

    task automatic set_time(int h24, int m);
        int hs, ms, n;
        hs = (h24 - m_sod / 3600 + 24) % 24;
        ms = (m - (m_sod / 60) % 60 + 60) % 60;
        n  = (hs > ms) ? hs : ms;
        if (n == 0) n = 1;
        Timeset = 1'b1;
        for (int i = 0; i < n; i++) begin
            Hrsadv = (i < hs);
            Minadv = (i < ms);
            step(1);
        end
        Hrsadv = 1'b0; Minadv = 1'b0; Timeset = 1'b0;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_thrs"}, thrs, 12);
        check({tag, "_tmin"}, tmin, 0);
        check({tag, "_tsec"}, tsec, 0);
        check({tag, "_tpm"},  tpm,  0);
        check({tag, "_ahrs"}, ahrs, 6);
        check({tag, "_amin"}, amin, 0);
        check({tag, "_apm"},  apm,  0);
        check({tag, "_alarm_out"}, alarm_out, 0);
    endtask

    initial begin
        Reset_n = 1'b0; Timeset = 0; Alarmset = 0; Minadv = 0; Hrsadv = 0; Alarmon = 0;
        model_reset();
        @(negedge Pulse); @(negedge Pulse);
        check_reset_vals("rst");
        Reset_n = 1'b1;

        // Minadv outside set modes with nothing ringing has no effect
        Minadv = 1'b1; step(3); Minadv = 1'b0;
        step(3597);
        check("hour1_thrs", thrs, 1); check("hour1_tmin", tmin, 0);
        check("hour1_tsec", tsec, 0); check("hour1_tpm", tpm, 0);

        // 11:59:59 AM -> 12:00:00 PM -> 1:00:00 PM
        set_time(11, 59);
        step(59);
        check("1159_thrs", thrs, 11); check("1159_tsec", tsec, 59); check("1159_tpm", tpm, 0);
        step(1);
        check("noon_thrs", thrs, 12); check("noon_tmin", tmin, 0); check("noon_tpm", tpm, 1);
        step(3600);
        check("1pm_thrs", thrs, 1); check("1pm_tmin", tmin, 0); check("1pm_tpm", tpm, 1);

        // set mode minute wrap has no hour carry
        set_time(0, 0);
        Timeset = 1'b1; Minadv = 1'b1; step(61); Minadv = 1'b0;
        check("set61_tmin", tmin, 1); check("set61_thrs", thrs, 12); check("set61_tsec", tsec, 0);
        Timeset = 1'b0;

        // ring for 30 s after 06:00:00
        set_time(5, 59);
        Alarmon = 1'b1;
        step(60);
        check("0600_tmin", tmin, 0); check("0600_alarm", alarm_out, 0);
        step(1);
        check("ring_start_tsec", tsec, 1); check("ring_start", alarm_out, 1);
        step(29);
        check("ring_last", alarm_out, 1);
        step(1);
        check("ring_done_tsec", tsec, 31); check("ring_done", alarm_out, 0);

        // alarm disabled: no ring
        Alarmon = 1'b0;
        set_time(5, 59);
        step(61);
        check("off_tsec", tsec, 1); check("off_alarm", alarm_out, 0);

        // Alarmon drop clears at next edge
        set_time(5, 59);
        Alarmon = 1'b1;
        step(65);
        check("drop_pre", alarm_out, 1);
        Alarmon = 1'b0; step(1);
        check("drop_post", alarm_out, 0);

`ifdef ALARM_SNOOZE_EN
        set_time(5, 59);
        Alarmon = 1'b1;
        step(65);
        check("snz_ringing", alarm_out, 1);
        Minadv = 1'b1; step(1); Minadv = 1'b0;
        check("snz_off", alarm_out, 0); check("snz_tmin", tmin, 0);
        step(299);
        check("snz_wait_tmin", tmin, 5); check("snz_wait", alarm_out, 0);
        step(1);
        check("snz_re_tsec", tsec, 6); check("snz_re", alarm_out, 1);
        step(40);
        Alarmon = 1'b0; step(1);
`endif

        // async reset mid-ring
        set_time(5, 59);
        Alarmon = 1'b1;
        step(65);
        check("arst_pre", alarm_out, 1);
        #2 Reset_n = 1'b0;
        model_reset();
        #1 check_reset_vals("arst");
        Alarmon = 1'b0;
        @(negedge Pulse);
        Reset_n = 1'b1;

        // Timeset while ringing holds the ring; Timeset beats Alarmset
        set_time(5, 59);
        Alarmon = 1'b1;
        step(65);
        Timeset = 1'b1; step(3);
        check("ts_ring_hold", alarm_out, 1); check("ts_tsec", tsec, 0);
        Alarmset = 1'b1; Hrsadv = 1'b1; step(1);
        check("both_thrs", thrs, 7); check("both_ahrs", ahrs, 6);
        Timeset = 1'b0; Minadv = 1'b1; step(2);
        Hrsadv = 1'b0; Minadv = 1'b0; Alarmset = 1'b0;
        check("aset_ahrs", ahrs, 8); check("aset_amin", amin, 2); check("aset_tsec", tsec, 2);
        step(40);
        Alarmon = 1'b0; step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/time_alarm_driver.md
# time_alarm_driver

Time-of-day and alarm-setting engine that drives the time (`tmin`, `thrs`, `tpm`) and alarm (`amin`, `ahrs`, `apm`) inputs of the alarm comparator. It consumes the comparator's `buzz` output and turns it into a timed, latched alarm output. It sits between the user buttons and the alarm comparator in the digital-clock top level, and is the only sequential state in that path.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 1: `Pulse` edges per second (prescaler modulus).
- `RING_SEC`, default 30: seconds the alarm output stays on once triggered.
- `SNOOZE_SEC`, default 300: snooze delay in seconds (used only with `ALARM_SNOOZE_EN`).

Ports:
- `Pulse`  in  1  clock; everything updates on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Timeset`  in  1  level; time-set mode.
- `Alarmset`  in  1  level; alarm-set mode.
- `Minadv`  in  1  level; advance minutes by one per cycle while held.
- `Hrsadv`  in  1  level; advance hours by one per cycle while held.
- `Alarmon`  in  1  level; alarm enable.
- `buzz`  in  1  time/alarm match from the comparator.
- `tsec`, `tmin`, `thrs`  out  7 each  current seconds, minutes, and hours (binary).
- `tpm`  out  1  current PM flag.
- `amin`, `ahrs`  out  7 each  alarm minutes and hours.
- `apm`  out  1  alarm PM flag.
- `alarm_out`  out  1  latched ring output.

## Operation
- Reset values:
  - time: `thrs`=12, `tmin`=0, `tsec`=0, `tpm`=0 (12:00:00 AM).
  - alarm: `ahrs`=6, `amin`=0, `apm`=0.
  - `alarm_out`=0; prescaler, ring counter, snooze counter and `buzz_d` all 0.
- Value ranges: minutes and seconds 0..59; hours 1..12; all values are 7-bit binary.
- Hour increment rule (shared by time and alarm): 11→12 toggles PM; 12→1 leaves PM unchanged; every other value increments by one.
- Run mode (`Timeset`=0):
  - The prescaler counts 0..TICKS_PER_SEC-1. On wrap, a one-cycle `sec_tick` fires.
  - On `sec_tick`, `tsec` increments; 59→0 carries into `tmin`; `tmin` 59→0 carries into hours.
- Time-set mode (`Timeset`=1):
  - Prescaler and `tsec` are held at 0.
  - `Minadv` increments `tmin` by one per cycle, wrapping 59→0 with no hour carry.
  - `Hrsadv` applies the hour rule once per cycle.
  - If both are high, both advance in the same cycle.
- Alarm-set mode (`Alarmset`=1, `Timeset`=0):
  - `Minadv` and `Hrsadv` edit `amin` and `ahrs`/`apm` with the same rules.
  - Time keeps running.
- `Timeset` and `Alarmset` both high: `Timeset` wins; the alarm registers are untouched.
- Ringing:
  - `buzz_d` registers `buzz` every cycle.
  - Trigger: `buzz`=1 and `buzz_d`=0 and `Alarmon`=1. `alarm_out` is set and the ring counter is loaded with RING_SEC.
  - The ring counter decrements on each `sec_tick`. When it reaches 0, `alarm_out` clears.
  - `Alarmon`=0 clears `alarm_out` and the ring counter on the next edge.
  - A trigger while already ringing reloads the ring counter.
  - Entering `Timeset` while ringing does not clear the ring.

## Timing
- `buzz` rises combinationally after the edge that makes the time match the alarm. `alarm_out` rises exactly one `Pulse` edge later.
- Set-mode edits are visible on the outputs one edge after the button is sampled high.
- `Reset_n` falling mid-ring or mid-set forces all reset values immediately, without waiting for a clock edge.
- Release of `Reset_n` is assumed synchronous to `Pulse` at the top level.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - Snooze request: `Minadv`=1 while `alarm_out`=1 and neither set mode is active. This clears `alarm_out` and loads the snooze counter with SNOOZE_SEC.
  - The snooze counter decrements on `sec_tick`. On reaching 0 with `Alarmon`=1, it retriggers ringing (RING_SEC reload) regardless of `buzz`.
  - `Alarmon`=0 cancels a pending snooze.
  - A snooze `Minadv` does not advance any register.
- `ALARM_SNOOZE_EN` not defined: there is no snooze counter, and `Minadv` outside the set modes is ignored.

## Structure
- Package `time_pkg`:
  - constants `MIN_MAX`=59, `SEC_MAX`=59, `HRS_MAX`=12, `HRS_MIN`=1;
  - typedef `hm_t` struct with fields `hrs[6:0]`, `min[6:0]`, `pm`.
- Sub-module `hm_reg`: one hh:mm:pm register with inputs `min_inc`, `min_carry_en`, `hrs_inc` and the reset value as a parameter. It is instantiated twice, once for time and once for alarm.
- Seconds, prescaler, ring and snooze logic live in the top module.

## Test plan
- Reset, then run 3600 s with `TICKS_PER_SEC`=1 → time reads 01:00:00 AM; the 12:59:59→1:00:00 step leaves `tpm`=0.
- Set time to 11:59:59 AM and run 1 s → 12:00:00 with `tpm`=1. Run 1 hour more → 01:00:00 PM.
- `Timeset`=1 with `Minadv` held for 61 cycles from 12:00 → `tmin`=1, `thrs`=12, `tsec`=0 throughout.
- Alarm 6:00 AM, `Alarmon`=1, time reaches 06:00:00 → `alarm_out`=1 from the next edge (`tsec`=1) for 30 s, then 0. With `Alarmon`=0 at the same time → `alarm_out` stays 0.
- Ringing, then `Alarmon` dropped → `alarm_out`=0 at the next edge. Ringing, then async `Reset_n` pulse → all outputs return to reset values immediately.
- With `ALARM_SNOOZE_EN`: ringing at 06:00:05, `Minadv` pulsed → `alarm_out`=0, re-rings at 06:05:06 for 30 s.
